// File: rtl/mb8_pipe_mac.sv
// Pipelined radix-8 Booth multiply-accumulate with signed/unsigned operands and optional running sum.
// Latency PIPE+1 cycles from acceptance to out_valid_o; one beat per cycle when not stalled.
// Backpressure: a held output (out_valid_o && !out_ready_i) freezes every stage; in_ready_o drops in the same cycle.
//
// Ports:
//   clk_i, rst_ni                 rising-edge clock, asynchronous active-low reset
//   in_valid_i / in_ready_o       operand handshake for a_i (multiplicand), b_i (multiplier), tc_i,
//                                 acc_en_i, acc_clr_i
//   out_valid_o / out_ready_i     result handshake for product_o (low 2*WIDTH bits) and acc_out_o
module mb8_pipe_mac #(
    parameter int WIDTH = 8,
    parameter int PIPE  = 2,
    parameter int ACCW  = 2 * WIDTH + 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 tc_i,
    input  logic                 acc_en_i,
    input  logic                 acc_clr_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic [ACCW-1:0]      acc_out_o
);

    localparam int XW  = WIDTH + 1;          // operand width after sign/zero extension
    localparam int PPW = WIDTH + 3;          // holds +/-4a for any extended operand
    localparam int G   = (WIDTH + 2) / 3 + 1;
    localparam int NT  = G + 1;              // G partial products plus the negate-carry word
    localparam int RW  = 2 * WIDTH;
    localparam int BW  = 3 * G;

    // Each partial product is stored with its sign bit inverted, which adds 2^(PPW-1) at its
    // weight; this constant removes all of those offsets at once so no sign extension is needed.
    function automatic logic [RW-1:0] corr_word();
        logic [RW-1:0] c;
        c = '0;
        for (int i = 0; i < G; i++) begin
            if (PPW - 1 + 3 * i < RW) begin
                c = c - (RW'(1) << (PPW - 1 + 3 * i));
            end
        end
        return c;
    endfunction

    localparam logic [RW-1:0] CORR = corr_word();

    logic stall;
    assign stall      = out_valid_o && !out_ready_i;
    assign in_ready_o = !stall;

    // ---------------- Booth encoding in front of stage 0 ----------------
    logic [XW-1:0]         a_x, b_x;
    logic [BW:0]           b_win;            // b_win[0] is the implicit b[-1] = 0
    logic signed [PPW-1:0] a_sx, a3_c;
    logic [G-1:0]          enc_s, enc_d, enc_t, enc_q, enc_n;

    always_comb begin : booth_enc
        a_x   = {tc_i & a_i[WIDTH-1], a_i};
        b_x   = {tc_i & b_i[WIDTH-1], b_i};
        b_win = {{(BW - XW){b_x[XW-1]}}, b_x, 1'b0};
        a_sx  = PPW'($signed(a_x));
        a3_c  = a_sx + (a_sx <<< 1);
        enc_s = '0;
        enc_d = '0;
        enc_t = '0;
        enc_q = '0;
        enc_n = '0;
        for (int i = 0; i < G; i++) begin
            case (b_win[3*i +: 4])
                4'b0001, 4'b0010: enc_s[i] = 1'b1;
                4'b0011, 4'b0100: enc_d[i] = 1'b1;
                4'b0101, 4'b0110: enc_t[i] = 1'b1;
                4'b0111:          enc_q[i] = 1'b1;
                4'b1000:          begin enc_q[i] = 1'b1; enc_n[i] = 1'b1; end
                4'b1001, 4'b1010: begin enc_t[i] = 1'b1; enc_n[i] = 1'b1; end
                4'b1011, 4'b1100: begin enc_d[i] = 1'b1; enc_n[i] = 1'b1; end
                4'b1101, 4'b1110: begin enc_s[i] = 1'b1; enc_n[i] = 1'b1; end
                default:          ;   // digit 0: 0000 and 1111
            endcase
        end
    end

    // ---------------- Pipeline control: index 0 is stage 0, index PIPE the last reduction stage
    logic [PIPE:0] vld_q, tc_q, en_q, clr_q;

    // ---------------- Stage 0 data ----------------
    logic [PPW-1:0] s0_a_q, s0_a3_q;
    logic [G-1:0]   s0_s_q, s0_d_q, s0_t_q, s0_q_q, s0_n_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q   <= '0;
            tc_q    <= '0;
            en_q    <= '0;
            clr_q   <= '0;
            s0_a_q  <= '0;
            s0_a3_q <= '0;
            s0_s_q  <= '0;
            s0_d_q  <= '0;
            s0_t_q  <= '0;
            s0_q_q  <= '0;
            s0_n_q  <= '0;
        end else if (!stall) begin
            vld_q   <= {vld_q[PIPE-1:0], in_valid_i};
            tc_q    <= {tc_q[PIPE-1:0],  tc_i};
            en_q    <= {en_q[PIPE-1:0],  acc_en_i};
            clr_q   <= {clr_q[PIPE-1:0], acc_clr_i};
            s0_a_q  <= a_sx;
            s0_a3_q <= a3_c;
            s0_s_q  <= enc_s;
            s0_d_q  <= enc_d;
            s0_t_q  <= enc_t;
            s0_q_q  <= enc_q;
            s0_n_q  <= enc_n;
        end
    end

    // ---------------- Partial-product generation from stage 0 ----------------
    logic [RW-1:0] pp_c [NT];

    always_comb begin : pp_gen
        logic [PPW-1:0] mag, inv, enc;
        mag = '0;
        inv = '0;
        enc = '0;
        for (int k = 0; k < NT; k++) pp_c[k] = '0;
        for (int i = 0; i < G; i++) begin
            mag = '0;
            if (s0_s_q[i])      mag = s0_a_q;
            else if (s0_d_q[i]) mag = s0_a_q << 1;
            else if (s0_t_q[i]) mag = s0_a3_q;
            else if (s0_q_q[i]) mag = s0_a_q << 2;
            // Negation is ~mag here; the +1 rides in the negate-carry word at the group weight.
            inv = s0_n_q[i] ? ~mag : mag;
            enc = {~inv[PPW-1], inv[PPW-2:0]};
            pp_c[i] = RW'(enc) << (3 * i);
            pp_c[G] = pp_c[G] | (RW'(s0_n_q[i]) << (3 * i));
        end
    end

    // ---------------- Reduction stages 1..PIPE ----------------
    // Intermediate stages add adjacent term pairs; the last stage sums what is left plus CORR.
    logic [RW-1:0] red_q [PIPE][NT];
    logic [RW-1:0] red_d [PIPE][NT];
    logic [RW-1:0] stg   [PIPE+1][NT];

    always_comb begin
        for (int k = 0; k < NT; k++) stg[0][k] = pp_c[k];
        for (int s = 0; s < PIPE; s++) begin
            for (int k = 0; k < NT; k++) stg[s+1][k] = red_q[s][k];
        end
    end

    always_comb begin
        for (int s = 0; s < PIPE; s++) begin
            for (int k = 0; k < NT; k++) red_d[s][k] = '0;
        end
        for (int s = 0; s < PIPE; s++) begin
            if (s == PIPE - 1) begin
                red_d[s][0] = CORR;
                for (int k = 0; k < NT; k++) red_d[s][0] = red_d[s][0] + stg[s][k];
            end else begin
                for (int k = 0; k < NT; k++) red_d[s][k/2] = red_d[s][k/2] + stg[s][k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < PIPE; s++) begin
                for (int k = 0; k < NT; k++) red_q[s][k] <= '0;
            end
        end else if (!stall) begin
            for (int s = 0; s < PIPE; s++) begin
                for (int k = 0; k < NT; k++) red_q[s][k] <= red_d[s][k];
            end
        end
    end

    // ---------------- Output register and accumulator ----------------
    logic [RW-1:0]   p_fin;
    logic [ACCW-1:0] p_ext, acc_base, acc_d, acc_q;
    logic            out_vld_q;
    logic [RW-1:0]   product_q;

    always_comb begin
        p_fin    = red_q[PIPE-1][0];
        p_ext    = tc_q[PIPE] ? ACCW'($signed(p_fin)) : ACCW'(p_fin);
        acc_base = clr_q[PIPE] ? '0 : acc_q;
        acc_d    = acc_q;
        if (en_q[PIPE])       acc_d = acc_base + p_ext;
        else if (clr_q[PIPE]) acc_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_q <= 1'b0;
            product_q <= '0;
            acc_q     <= '0;
        end else if (!stall) begin
            out_vld_q <= vld_q[PIPE];
            if (vld_q[PIPE]) begin
                product_q <= p_fin;
                acc_q     <= acc_d;
            end
        end
    end

    assign out_valid_o = out_vld_q;
    assign product_o   = product_q;
    assign acc_out_o   = acc_q;

endmodule

// File: tb/tb_mb8_pipe_mac.sv
// Directed and table-driven bench for mb8_pipe_mac at WIDTH=8, PIPE=2, ACCW=20.
// Expected results are queued at acceptance and compared in order at each output transfer.
// Output handshake is sampled on the falling edge; inputs change 1 ns after the rising edge.
module tb_mb8_pipe_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, tc, acc_en, acc_clr, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [15:0] product;
    logic [19:0] acc_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mb8_pipe_mac #(.WIDTH(8), .PIPE(2), .ACCW(20)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .tc_i        (tc),
        .acc_en_i    (acc_en),
        .acc_clr_i   (acc_clr),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .product_o   (product),
        .acc_out_o   (acc_out)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        tc;
        logic        en;
        logic        clr;
        logic [15:0] p;
        logic [19:0] acc;
    } vec_t;

    vec_t        tbl [18];
    logic [15:0] exp_p_q [$];
    logic [19:0] exp_a_q [$];
    logic [19:0] acc_m;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Output monitor: in-order scoreboard plus hold checks while stalled.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_p;
    logic [19:0] prev_acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                chk("in_ready_stall", {31'b0, in_ready}, 32'd0);
                if (prev_stall) begin
                    chk("hold_product", {16'b0, product}, {16'b0, prev_p});
                    chk("hold_acc", {12'b0, acc_out}, {12'b0, prev_acc});
                end
            end
            if (out_valid && out_ready) begin
                if (exp_p_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat product=%0h acc=%0h at %0t", product, acc_out, $time);
                end else begin
                    chk("product", {16'b0, product}, {16'b0, exp_p_q.pop_front()});
                    chk("acc_out", {12'b0, acc_out}, {12'b0, exp_a_q.pop_front()});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_p     = product;
            prev_acc   = acc_out;
        end
    end

    // Offers one beat and returns 1 ns after the edge that accepts it, in_valid still high.
    task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic itc,
                        input logic ien, input logic iclr,
                        input logic [15:0] ep, input logic [19:0] ea);
        bit done;
        done     = 1'b0;
        a        = ia;
        b        = ib;
        tc       = itc;
        acc_en   = ien;
        acc_clr  = iclr;
        in_valid = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_p_q.push_back(ep);
                exp_a_q.push_back(ea);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout a=%0h b=%0h", ia, ib);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 100 && exp_p_q.size() != 0; c++) @(posedge clk);
        #1;
        chk(name, exp_p_q.size(), 32'd0);
    endtask

    // Behavioural reference: plain multiply, then the accumulator rules.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mtc,
                         input logic men, input logic mclr,
                         output logic [15:0] p, output logic [19:0] acc);
        logic [15:0]        ua, ub;
        logic signed [15:0] sa, sb;
        logic [19:0]        ext, base;
        ua = {8'b0, ma};
        ub = {8'b0, mb};
        sa = $signed(ma);
        sb = $signed(mb);
        p  = mtc ? 16'(sa * sb) : 16'(ua * ub);
        ext  = mtc ? {{4{p[15]}}, p} : {4'b0, p};
        base = mclr ? 20'd0 : acc_m;
        if (men)       acc_m = base + ext;
        else if (mclr) acc_m = 20'd0;
        acc = acc_m;
    endtask

    bit rnd_done;

    initial begin
        //            a      b      tc    en    clr   product   acc
        tbl[0]  = '{8'h80, 8'h80, 1'b1, 1'b0, 1'b1, 16'h4000, 20'h00000};
        tbl[1]  = '{8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 16'hFFFF, 20'h00000};
        tbl[2]  = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 16'hC080, 20'h00000};
        tbl[3]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 16'hFE01, 20'h00000};
        tbl[4]  = '{8'h80, 8'h02, 1'b0, 1'b0, 1'b0, 16'h0100, 20'h00000};
        tbl[5]  = '{8'h00, 8'hC8, 1'b0, 1'b0, 1'b0, 16'h0000, 20'h00000};
        tbl[6]  = '{8'h03, 8'h04, 1'b1, 1'b1, 1'b1, 16'h000C, 20'h0000C};
        tbl[7]  = '{8'h05, 8'h06, 1'b1, 1'b1, 1'b0, 16'h001E, 20'h0002A};
        tbl[8]  = '{8'hFE, 8'h07, 1'b1, 1'b1, 1'b0, 16'hFFF2, 20'h0001C};
        tbl[9]  = '{8'h09, 8'h09, 1'b1, 1'b0, 1'b0, 16'h0051, 20'h0001C};
        tbl[10] = '{8'hC8, 8'h64, 1'b0, 1'b1, 1'b0, 16'h4E20, 20'h04E3C};
        tbl[11] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 16'h0001, 20'h04E3D};
        tbl[12] = '{8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 16'h4000, 20'h08E3D};
        tbl[13] = '{8'h7F, 8'h80, 1'b1, 1'b1, 1'b1, 16'hC080, 20'hFC080};
        tbl[14] = '{8'hFF, 8'h02, 1'b1, 1'b1, 1'b0, 16'hFFFE, 20'hFC07E};
        tbl[15] = '{8'hFF, 8'h02, 1'b0, 1'b1, 1'b0, 16'h01FE, 20'hFC27C};
        tbl[16] = '{8'h55, 8'h33, 1'b0, 1'b0, 1'b1, 16'h10EF, 20'h00000};
        tbl[17] = '{8'hAB, 8'h0D, 1'b1, 1'b1, 1'b0, 16'hFBAF, 20'hFFBAF};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; tc = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
        acc_m = '0;

        // Reset state
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_product", {16'b0, product}, 32'd0);
        chk("rst_acc", {12'b0, acc_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Latency: result visible exactly three edges after acceptance
        send(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 16'h4000, 20'h0);
        in_valid = 1'b0;
        chk("lat_k0", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_k1", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_k2", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_k3", {31'b0, out_valid}, 32'd1);
        drain("lat_drain");

        // Table: corners and accumulate sequence, streamed back to back
        for (int i = 0; i < 18; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].tc, tbl[i].en, tbl[i].clr, tbl[i].p, tbl[i].acc);
        end
        idle(1);
        drain("table_drain");

        // Backpressure: six beats, sink stalled for cycles 4..8
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(8'(10 + i), 8'(20 + i), 1'b0, 1'b0, 1'b0,
                         16'((10 + i) * (20 + i)), 20'hFFBAF);
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    @(posedge clk); #1;
                    out_ready = !(c >= 4 && c <= 8);
                end
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");

        // Reset with three beats in flight
        acc_m = 20'hFFBAF;
        send(8'h11, 8'h11, 1'b0, 1'b1, 1'b0, 16'h0, 20'h0);
        send(8'h12, 8'h12, 1'b0, 1'b1, 1'b0, 16'h0, 20'h0);
        send(8'h13, 8'h13, 1'b0, 1'b1, 1'b0, 16'h0, 20'h0);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_acc", {12'b0, acc_out}, 32'd0);
        exp_p_q.delete();
        exp_a_q.delete();
        acc_m = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle(10);
        send(8'h07, 8'h07, 1'b1, 1'b1, 1'b0, 16'h0031, 20'h00031);
        in_valid = 1'b0;
        drain("midrst_drain");

        // Random operands with random valid/ready, checked against the reference model
        acc_m    = '0;
        rnd_done = 1'b0;
        fork
            begin
                logic [7:0]  ra, rb;
                logic        rtc, ren, rclr;
                logic [15:0] ep;
                logic [19:0] ea;
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    ra   = 8'($urandom);
                    rb   = 8'($urandom);
                    rtc  = 1'($urandom);
                    ren  = ($urandom_range(0, 3) != 0);
                    rclr = (i == 0) || ($urandom_range(0, 7) == 0);
                    model(ra, rb, rtc, ren, rclr, ep, ea);
                    send(ra, rb, rtc, ren, rclr, ep, ea);
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                for (int c = 0; c < 5000 && !rnd_done; c++) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
